// File: rtl/velocity_smoother_if.sv
// Sample stream into the smoother and result stream out of it (avg side has valid/ready).
interface velocity_smoother_if;
    logic               vel_valid;
    logic signed [15:0] velocity;
    logic               avg_valid;
    logic signed [15:0] avg_velocity;
    logic               avg_ready;

    modport master (
        output vel_valid, velocity, avg_ready,
        input  avg_valid, avg_velocity
    );

    modport slave (
        input  vel_valid, velocity, avg_ready,
        output avg_valid, avg_velocity
    );
endinterface

// File: rtl/velocity_smoother.sv
// Moving-average smoother for signed Doppler velocity over a 2^WIN_LOG2 sample window.
// Latency 1 cycle from vel_valid to avg_valid; optional outlier rejection via VEL_OUTLIER_REJECT_EN.
// No input backpressure; unaccepted results are overwritten by newer ones and flagged in overrun.
module velocity_smoother #(
    parameter int          WIN_LOG2 = 3,
    parameter logic [15:0] MAX_STEP = 16'd2000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    velocity_smoother_if.slave  bus,
    output logic                filled,
    output logic                overrun,
    output logic [7:0]          reject_cnt
);
    localparam int WIN = 1 << WIN_LOG2;
    localparam int SW  = 16 + WIN_LOG2;
    localparam int CW  = WIN_LOG2 + 1;
    localparam logic [CW-1:0] LAST_FILL = CW'(WIN - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t                    state;
    logic signed [15:0]        win_buf [WIN];
    logic [WIN_LOG2-1:0]       wr_ptr;
    logic [CW-1:0]             fill_cnt;
    logic signed [SW-1:0]      sum;
    logic signed [SW-1:0]      sum_next;
    logic signed [15:0]        sample_w;
    logic signed [15:0]        result;
    logic signed [15:0]        avg_q;
    logic                      avg_vld_q;
    logic                      produce;
    logic                      reject;

    assign bus.avg_valid    = avg_vld_q;
    assign bus.avg_velocity = avg_q;

`ifdef VEL_OUTLIER_REJECT_EN
    logic signed [15:0] last_acc;
    logic signed [16:0] diff;
    logic [16:0]        mag;

    always_comb begin
        sample_w = bus.velocity;
        reject   = 1'b0;
        diff     = 17'(bus.velocity) - 17'(last_acc);
        mag      = diff[16] ? -diff : diff;
        if (state == RUN && mag > {1'b0, MAX_STEP}) begin
            sample_w = last_acc;
            reject   = 1'b1;
        end
    end

    // last_acc follows the value written into the window, so a replaced sample repeats it
    always_ff @(posedge clk) begin
        if (reset) begin
            last_acc   <= '0;
            reject_cnt <= '0;
        end else if (!flush && bus.vel_valid) begin
            last_acc <= sample_w;
            if (reject && reject_cnt != 8'hFF)
                reject_cnt <= reject_cnt + 8'd1;
        end
    end
`else
    logic unused_cfg;

    assign sample_w   = bus.velocity;
    assign reject     = 1'b0;
    assign reject_cnt = 8'd0;
    assign unused_cfg = ^{MAX_STEP, reject};
`endif

    always_comb begin
        sum_next = sum + SW'(sample_w) - SW'(win_buf[wr_ptr]);
        result   = 16'(sum_next >>> WIN_LOG2);
        produce  = (state == RUN) || (fill_cnt == LAST_FILL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
            state     <= FILL;
            filled    <= 1'b0;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            sum       <= '0;
            avg_q     <= '0;
            avg_vld_q <= 1'b0;
            overrun   <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
            state     <= FILL;
            filled    <= 1'b0;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            sum       <= '0;
            avg_vld_q <= 1'b0;
        end else if (bus.vel_valid) begin
            win_buf[wr_ptr] <= sample_w;
            sum             <= sum_next;
            wr_ptr          <= wr_ptr + 1'b1;
            if (state == FILL) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (fill_cnt == LAST_FILL) begin
                    state  <= RUN;
                    filled <= 1'b1;
                end
            end
            if (produce) begin
                avg_q     <= result;
                avg_vld_q <= 1'b1;
                if (avg_vld_q && !bus.avg_ready)
                    overrun <= 1'b1;
            end else if (avg_vld_q && bus.avg_ready) begin
                avg_vld_q <= 1'b0;
            end
        end else if (avg_vld_q && bus.avg_ready) begin
            avg_vld_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_velocity_smoother.sv
// Directed-vector bench for velocity_smoother (default WIN_LOG2=3, window of 8).
module tb_velocity_smoother;
    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       filled;
    logic       overrun;
    logic [7:0] reject_cnt;
    int         checks   = 0;
    int         failures = 0;

    velocity_smoother_if bus();

    velocity_smoother dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .bus        (bus),
        .filled     (filled),
        .overrun    (overrun),
        .reject_cnt (reject_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] s);
        @(negedge clk);
        bus.vel_valid = 1'b1;
        bus.velocity  = s;
        @(posedge clk);
        #1;
        bus.vel_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic with_sample);
        @(negedge clk);
        flush         = 1'b1;
        bus.vel_valid = with_sample;
        bus.velocity  = 16'sd999;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        bus.vel_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        flush         = 1'b0;
        bus.vel_valid = 1'b0;
        bus.velocity  = '0;
        bus.avg_ready = 1'b1;
        do_reset();
        check("rst_avg_valid", bus.avg_valid, 0);
        check("rst_avg_velocity", $signed(bus.avg_velocity), 0);
        check("rst_filled", filled, 0);
        check("rst_overrun", overrun, 0);
        check("rst_reject_cnt", reject_cnt, 0);

        // first fill: nothing until the 8th sample
        for (int i = 0; i < 7; i++) begin
            send(16'sd100);
            check("fill_no_valid", bus.avg_valid, 0);
        end
        send(16'sd100);
        check("fill8_valid", bus.avg_valid, 1);
        check("fill8_avg", $signed(bus.avg_velocity), 100);
        check("fill8_filled", filled, 1);
        idle();
        check("drain_valid", bus.avg_valid, 0);

        // step response from a window of zeros
        do_flush(1'b0);
        check("flush_filled", filled, 0);
        for (int i = 0; i < 8; i++) send(16'sd0);
        send(16'sd80);
        check("step_first", $signed(bus.avg_velocity), 10);
        for (int i = 0; i < 7; i++) send(16'sd80);
        check("step_final", $signed(bus.avg_velocity), 80);
        check("stream_no_overrun", overrun, 0);
        check("stream_valid_held", bus.avg_valid, 1);

        // floor toward minus infinity
        do_flush(1'b0);
        for (int i = 0; i < 7; i++) send(16'sd0);
        send(-16'sd1);
        check("neg_floor", $signed(bus.avg_velocity), -1);
        do_flush(1'b0);
        for (int i = 0; i < 8; i++) send(-16'sd3);
        check("neg_three", $signed(bus.avg_velocity), -3);

        // overwrite while stalled
        do_flush(1'b0);
        for (int i = 0; i < 8; i++) send(16'sd0);
        idle();
        bus.avg_ready = 1'b0;
        send(16'sd8);
        check("stall_first_avg", $signed(bus.avg_velocity), 1);
        check("stall_first_overrun", overrun, 0);
        send(16'sd16);
        check("overwrite_avg", $signed(bus.avg_velocity), 3);
        check("overwrite_overrun", overrun, 1);
        idle();
        check("hold_valid", bus.avg_valid, 1);
        check("hold_avg", $signed(bus.avg_velocity), 3);
        @(negedge clk);
        bus.avg_ready = 1'b1;
        @(posedge clk);
        #1;
        check("accept_drop", bus.avg_valid, 0);

        // flush mid-window; the sample in the flush cycle is dropped
        do_flush(1'b0);
        for (int i = 0; i < 5; i++) send(16'sd50);
        do_flush(1'b1);
        check("midflush_filled", filled, 0);
        check("midflush_valid", bus.avg_valid, 0);
        check("overrun_sticky", overrun, 1);
        for (int i = 0; i < 7; i++) begin
            send(16'sd40);
            check("refill_no_valid", bus.avg_valid, 0);
        end
        send(16'sd40);
        check("refill_valid", bus.avg_valid, 1);
        check("refill_avg", $signed(bus.avg_velocity), 40);

        // reset mid-window
        do_flush(1'b0);
        for (int i = 0; i < 3; i++) send(16'sd70);
        do_reset();
        check("midrst_overrun", overrun, 0);
        check("midrst_filled", filled, 0);
        for (int i = 0; i < 7; i++) send(16'sd20);
        check("midrst_no_valid", bus.avg_valid, 0);
        send(16'sd20);
        check("midrst_avg", $signed(bus.avg_velocity), 20);

        // outlier in steady state
        for (int i = 0; i < 8; i++) send(16'sd100);
        check("steady_avg", $signed(bus.avg_velocity), 100);
        send(16'sd5000);
`ifdef VEL_OUTLIER_REJECT_EN
        check("outlier_avg", $signed(bus.avg_velocity), 100);
        check("outlier_reject_cnt", reject_cnt, 1);
        send(16'sd100);
        check("after_outlier", $signed(bus.avg_velocity), 100);
`else
        check("outlier_avg", $signed(bus.avg_velocity), 712);
        check("outlier_reject_cnt", reject_cnt, 0);
        send(16'sd100);
        check("after_outlier", $signed(bus.avg_velocity), 712);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/velocity_smoother.md
VELOCITY_SMOOTHER -- requirements
Module: velocity_smoother

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 3: moving-average window is 2^WIN_LOG2 samples (legal 1..6).
REQ-002 SHALL have parameter MAX_STEP, default 16'd2000: outlier threshold, unsigned, used only when VEL_OUTLIER_REJECT_EN is defined.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port vel_valid, input, 1: qualifies velocity, one sample per asserted cycle, no backpressure.
REQ-006 SHALL have port velocity, input, 16: signed two's-complement velocity sample from the Doppler stage.
REQ-007 SHALL have port flush, input, 1: synchronous clear of the window contents and state.
REQ-008 SHALL have port avg_ready, input, 1: downstream accepts avg_velocity.
REQ-009 SHALL have port avg_velocity, output, 16: signed smoothed velocity.
REQ-010 SHALL have port avg_valid, output, 1: avg_velocity is valid; held until accepted.
REQ-011 SHALL have port filled, output, 1: high in RUN state.
REQ-012 SHALL have port overrun, output, 1: sticky flag, set when an unaccepted result is overwritten.
REQ-013 SHALL have port reject_cnt, output, 8: saturating count of outlier-replaced samples.

Function
REQ-014 SHALL hold 2^WIN_LOG2 x 16-bit circular buffer, write pointer, fill counter, signed running sum of 16+WIN_LOG2 bits.
REQ-015 SHALL, per accepted sample s, compute sum_next = sum + s - buf[wr_ptr], write buf[wr_ptr]=s, advance wr_ptr modulo window; wrap from last index to 0.
REQ-016 SHALL implement states FILL (after reset/flush) and RUN; FILL->RUN on the sample that makes the fill count reach 2^WIN_LOG2; RUN->FILL only on flush or reset.
REQ-017 SHALL produce no result in FILL except on the transition sample; in RUN every accepted sample produces one result.
REQ-018 SHALL compute result = sum_next arithmetically right-shifted by WIN_LOG2 (floor toward minus infinity), truncated to 16 bits; no overflow is possible.
REQ-019 SHALL register the result: avg_valid and avg_velocity update on the clock edge following the vel_valid cycle (latency 1).
REQ-020 SHALL hold avg_velocity/avg_valid stable while avg_valid=1 and avg_ready=0; avg_valid deasserts on the edge following avg_valid&&avg_ready with no new result.
REQ-021 SHALL, when a new result arrives while avg_valid=1 and avg_ready=0, overwrite with the newest result and set overrun; with avg_ready=1 in that cycle, no overrun and avg_valid stays high.
REQ-022 SHALL on flush zero buffer, sum, pointer, fill counter, drop avg_valid, enter FILL; a vel_valid sample in the flush cycle is discarded; overrun and reject_cnt are not cleared by flush.

Reset
REQ-023 SHALL on reset clear avg_velocity=0, avg_valid=0, filled=0, overrun=0, reject_cnt=0, buffer/sum/pointers=0, state=FILL.
REQ-024 SHALL give reset priority over flush and vel_valid; reset asserted mid-window discards all partial contents.

Configuration
REQ-025 SHALL, with VEL_OUTLIER_REJECT_EN defined, in RUN replace any sample with |s - last_accepted| > MAX_STEP by last_accepted and increment reject_cnt (saturate at 255); samples in FILL are never rejected; last_accepted tracks the value actually written.
REQ-026 SHALL, without VEL_OUTLIER_REJECT_EN, use every sample unmodified and tie reject_cnt to 0.

Verification
REQ-027 SHALL cover: reset, 8 samples of 100 with avg_ready=1 -> no avg_valid for samples 1..7, one cycle after sample 8 avg_valid=1, avg_velocity=100, filled=1.
REQ-028 SHALL cover: window of 0s filled, then one sample 80 -> avg_velocity=10; 7 more samples 80 -> final result 80.
REQ-029 SHALL cover: fill with seven 0s and one -1 -> avg_velocity=-1 (0xFFFF); fill with eight -3 -> -3.
REQ-030 SHALL cover: RUN, avg_ready=0, two samples 8 then 16 (window otherwise 0) -> avg_velocity=3 (24>>>3), overrun=1; avg_ready=1 -> avg_valid drops next cycle.
REQ-031 SHALL cover: 5 samples then flush -> filled=0, avg_valid=0; next result only after 8 further samples.
REQ-032 SHALL cover: macro defined, RUN at steady 100, sample 5000 -> stored 100, avg_velocity=100, reject_cnt=1; macro undefined -> avg_velocity=712, reject_cnt=0.
